// File: rtl/mem_arbiter_if.sv
// Bundle of requester-side and RAM-side signals around the memory arbiter.
// slave is the arbiter's view; master is the view of everything around it.
interface mem_arbiter_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;

    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (icache/dcache) arbiter for a single RAM port, with optional
// round-robin fairness under contention.
//
//   state  | meaning
//   IDLE   | no grant; RAM port quiet; arbitrate pending requests
//   IGRANT | icache owns the RAM port until ACCESS or request drop
//   DGRANT | dcache owns the RAM port until ACCESS or request drop
module mem_arbiter #(
    parameter bit FAIR = 1'b1
) (
    input  logic          CLK,
    input  logic          nRST,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } state_t;

    localparam logic [1:0] RAM_ACCESS = 2'd2;

    state_t state, next_state;
    logic   last_d, next_last_d;
    logic   d_req;
    logic   access;

    assign d_req  = bus.dREN | bus.dWEN;
    assign access = (bus.ramstate == RAM_ACCESS);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= IDLE;
            last_d <= 1'b0;
        end else begin
            state  <= next_state;
            last_d <= next_last_d;
        end
    end

    // ACCESS is checked before a request drop so a completing transfer is
    // always recorded, even if the requester lets go in that same cycle.
    always_comb begin
        next_state  = state;
        next_last_d = last_d;
        case (state)
            IDLE: begin
                if (d_req && bus.iREN)
                    next_state = (FAIR && last_d) ? IGRANT : DGRANT;
                else if (d_req)
                    next_state = DGRANT;
                else if (bus.iREN)
                    next_state = IGRANT;
            end
            IGRANT: begin
                if (access) begin
                    next_state  = IDLE;
                    next_last_d = 1'b0;
                end else if (!bus.iREN) begin
                    next_state = IDLE;
                end
            end
            DGRANT: begin
                if (access) begin
                    next_state  = IDLE;
                    next_last_d = 1'b1;
                end else if (!d_req) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = 32'h0;
        bus.ramstore = 32'h0;
        bus.iwait    = 1'b1;
        bus.dwait    = 1'b1;
        case (state)
            IGRANT: begin
                bus.ramREN  = 1'b1;
                bus.ramaddr = bus.iaddr;
                bus.iwait   = ~access;
            end
            DGRANT: begin
                bus.ramWEN   = bus.dWEN;
                bus.ramREN   = bus.dREN & ~bus.dWEN;
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                bus.dwait    = ~access;
            end
            default: ;
        endcase
    end

    assign bus.iload = bus.ramload;
    assign bus.dload = bus.ramload;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a fair and a strict instance driven in lockstep and
// compared every cycle against a transaction-level ownership model.
module tb_mem_arbiter;
    localparam int NONE  = 0;
    localparam int OWN_I = 1;
    localparam int OWN_D = 2;

    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;

    mem_arbiter_if bus0 ();
    mem_arbiter_if bus1 ();

    assign bus0.iREN = iREN;   assign bus1.iREN = iREN;
    assign bus0.iaddr = iaddr; assign bus1.iaddr = iaddr;
    assign bus0.dREN = dREN;   assign bus1.dREN = dREN;
    assign bus0.dWEN = dWEN;   assign bus1.dWEN = dWEN;
    assign bus0.daddr = daddr; assign bus1.daddr = daddr;
    assign bus0.dstore = dstore;     assign bus1.dstore = dstore;
    assign bus0.ramload = ramload;   assign bus1.ramload = ramload;
    assign bus0.ramstate = ramstate; assign bus1.ramstate = ramstate;

    mem_arbiter #(.FAIR(1'b1)) u_fair   (.CLK(CLK), .nRST(nRST), .bus(bus0.slave));
    mem_arbiter #(.FAIR(1'b0)) u_strict (.CLK(CLK), .nRST(nRST), .bus(bus1.slave));

    int checks = 0;
    int errors = 0;
    int owner [2];
    bit last_d [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic compare(input int k, input logic rren, input logic rwen,
                           input logic [31:0] raddr, input logic [31:0] rstore,
                           input logic iw, input logic dw,
                           input logic [31:0] il, input logic [31:0] dl);
        logic        e_ren, e_wen, e_iw, e_dw;
        logic [31:0] e_addr, e_store;
        e_ren = 1'b0; e_wen = 1'b0; e_iw = 1'b1; e_dw = 1'b1;
        e_addr = 32'h0; e_store = 32'h0;
        if (owner[k] == OWN_I) begin
            e_ren  = 1'b1;
            e_addr = iaddr;
            e_iw   = (ramstate != 2'd2);
        end else if (owner[k] == OWN_D) begin
            e_wen   = dWEN;
            e_ren   = dREN && !dWEN;
            e_addr  = daddr;
            e_store = dstore;
            e_dw    = (ramstate != 2'd2);
        end
        chk($sformatf("dut%0d ramREN", k), 32'(rren), 32'(e_ren));
        chk($sformatf("dut%0d ramWEN", k), 32'(rwen), 32'(e_wen));
        chk($sformatf("dut%0d ramaddr", k), raddr, e_addr);
        chk($sformatf("dut%0d ramstore", k), rstore, e_store);
        chk($sformatf("dut%0d iwait", k), 32'(iw), 32'(e_iw));
        chk($sformatf("dut%0d dwait", k), 32'(dw), 32'(e_dw));
        chk($sformatf("dut%0d iload", k), il, ramload);
        chk($sformatf("dut%0d dload", k), dl, ramload);
        chk($sformatf("dut%0d ren_wen_excl", k), 32'(rren & rwen), 32'h0);
    endtask

    // One arbitration decision per edge: who owns the port after this cycle.
    task automatic model_step();
        bit dq;
        dq = dREN || dWEN;
        for (int k = 0; k < 2; k++) begin
            if (owner[k] == NONE) begin
                if (dq && iREN)
                    owner[k] = (k == 0 && last_d[k]) ? OWN_I : OWN_D;
                else if (dq)
                    owner[k] = OWN_D;
                else if (iREN)
                    owner[k] = OWN_I;
            end else if (ramstate == 2'd2) begin
                last_d[k] = (owner[k] == OWN_D);
                owner[k]  = NONE;
            end else if ((owner[k] == OWN_I && !iREN) || (owner[k] == OWN_D && !dq)) begin
                owner[k] = NONE;
            end
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        compare(0, bus0.ramREN, bus0.ramWEN, bus0.ramaddr, bus0.ramstore,
                bus0.iwait, bus0.dwait, bus0.iload, bus0.dload);
        compare(1, bus1.ramREN, bus1.ramWEN, bus1.ramaddr, bus1.ramstore,
                bus1.iwait, bus1.dwait, bus1.iload, bus1.dload);
        @(posedge CLK);
        model_step();
        #1;
    endtask

    task automatic pulse_reset();
        nRST = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            owner[k]  = NONE;
            last_d[k] = 1'b0;
        end
        chk("rst ramREN", 32'(bus0.ramREN), 32'h0);
        chk("rst ramWEN", 32'(bus0.ramWEN), 32'h0);
        chk("rst ramaddr", bus0.ramaddr, 32'h0);
        chk("rst ramstore", bus0.ramstore, 32'h0);
        chk("rst iwait", 32'(bus0.iwait), 32'h1);
        chk("rst dwait", 32'(bus0.dwait), 32'h1);
        chk("rst strict ramREN", 32'(bus1.ramREN), 32'h0);
        chk("rst strict ramWEN", 32'(bus1.ramWEN), 32'h0);
        nRST = 1'b1;
    endtask

    task automatic clear_inputs();
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = 32'h0; daddr = 32'h0; dstore = 32'h0;
        ramload = 32'h0; ramstate = 2'd0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] seq0, seq1;
        int          wen_cnt, dlow_cnt;
        logic        ilow;

        clear_inputs();
        pulse_reset();
        tick();

        // Single icache read, ACCESS in cycle 2
        iREN = 1'b1; iaddr = 32'h40; ramload = 32'hDEADBEEF;
        #1 chk("i_rd c0 ramREN", 32'(bus0.ramREN), 32'h0);
        tick();
        #1 chk("i_rd c1 ramREN", 32'(bus0.ramREN), 32'h1);
        chk("i_rd c1 ramaddr", bus0.ramaddr, 32'h40);
        chk("i_rd c1 iwait", 32'(bus0.iwait), 32'h1);
        tick();
        ramstate = 2'd2;
        #1 chk("i_rd c2 iwait", 32'(bus0.iwait), 32'h0);
        chk("i_rd c2 iload", bus0.iload, 32'hDEADBEEF);
        tick();
        iREN = 1'b0; ramstate = 2'd0;
        #1 chk("i_rd c3 iwait", 32'(bus0.iwait), 32'h1);
        chk("i_rd c3 ramREN", 32'(bus0.ramREN), 32'h0);
        tick();

        // dcache write, BUSY x3 then ACCESS
        dWEN = 1'b1; daddr = 32'h100; dstore = 32'h12345678;
        tick();
        wen_cnt = 0; dlow_cnt = 0;
        for (int n = 0; n < 4; n++) begin
            ramstate = (n < 3) ? 2'd1 : 2'd2;
            #1;
            if (bus0.ramWEN && bus0.ramstore == 32'h12345678 && bus0.ramaddr == 32'h100) wen_cnt++;
            if (!bus0.dwait) dlow_cnt++;
            tick();
        end
        dWEN = 1'b0; ramstate = 2'd0;
        #1;
        if (bus0.ramWEN) wen_cnt++;
        if (!bus0.dwait) dlow_cnt++;
        chk("d_wr ramWEN cycles", 32'(wen_cnt), 32'd4);
        chk("d_wr dwait low cycles", 32'(dlow_cnt), 32'd1);
        tick();

        // Contention: fair alternates D,I,D,I; strict grants only D
        pulse_reset();
        iREN = 1'b1; dREN = 1'b1; iaddr = 32'h200; daddr = 32'h300; ramstate = 2'd2;
        seq0 = 32'h0; seq1 = 32'h0; ilow = 1'b0;
        for (int n = 0; n < 8; n++) begin
            #1;
            if (!bus0.dwait) seq0 = {seq0[27:0], 4'h1};
            if (!bus0.iwait) seq0 = {seq0[27:0], 4'h2};
            if (!bus1.dwait) seq1 = {seq1[27:0], 4'h1};
            if (!bus1.iwait) begin seq1 = {seq1[27:0], 4'h2}; ilow = 1'b1; end
            tick();
        end
        chk("fair grant order", seq0, 32'h1212);
        chk("strict grant order", seq1, 32'h1111);
        chk("strict iwait never low", 32'(ilow), 32'h0);
        clear_inputs();
        tick();

        // ERROR is not a completion
        dREN = 1'b1; daddr = 32'h44;
        tick();
        for (int n = 0; n < 2; n++) begin
            ramstate = 2'd3;
            #1 chk("d_err ramREN held", 32'(bus0.ramREN), 32'h1);
            chk("d_err dwait", 32'(bus0.dwait), 32'h1);
            tick();
        end
        ramstate = 2'd2;
        #1 chk("d_err access dwait", 32'(bus0.dwait), 32'h0);
        tick();
        dREN = 1'b0; ramstate = 2'd0;
        #1 chk("d_err done ramREN", 32'(bus0.ramREN), 32'h0);
        tick();

        // Reset during IGRANT with dREN pending
        iREN = 1'b1; iaddr = 32'h80; ramstate = 2'd1;
        tick();
        #1 chk("rst_mid igrant ramREN", 32'(bus0.ramREN), 32'h1);
        dREN = 1'b1; daddr = 32'h90;
        pulse_reset();
        tick();
        #1 chk("rst_mid regrant addr", bus0.ramaddr, 32'h90);
        chk("rst_mid regrant strict addr", bus1.ramaddr, 32'h90);
        chk("rst_mid iwait", 32'(bus0.iwait), 32'h1);
        ramstate = 2'd2;
        tick();
        clear_inputs();
        tick();

        // Read+write together, then icache drop mid-grant
        dREN = 1'b1; dWEN = 1'b1; daddr = 32'h10; dstore = 32'hA5A5A5A5; ramstate = 2'd1;
        tick();
        #1 chk("rw ramWEN", 32'(bus0.ramWEN), 32'h1);
        chk("rw ramREN", 32'(bus0.ramREN), 32'h0);
        ramstate = 2'd2;
        tick();
        dREN = 1'b0; dWEN = 1'b0; ramstate = 2'd1; iREN = 1'b1; iaddr = 32'h20;
        tick();
        ilow = 1'b0;
        #1 chk("idrop grant ramREN", 32'(bus0.ramREN), 32'h1);
        iREN = 1'b0;
        #1 if (!bus0.iwait) ilow = 1'b1;
        tick();
        #1 if (!bus0.iwait) ilow = 1'b1;
        chk("idrop idle ramREN", 32'(bus0.ramREN), 32'h0);
        chk("idrop iwait never low", 32'(ilow), 32'h0);
        tick();

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) iREN = ~iREN;
            if ($urandom_range(0, 3) == 0) dREN = ~dREN;
            if ($urandom_range(0, 5) == 0) dWEN = ~dWEN;
            iaddr    = $urandom;
            daddr    = $urandom;
            dstore   = $urandom;
            ramload  = $urandom;
            ramstate = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) pulse_reset();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
